uart_rom_loader: RTL

- Writer side of the instruction ROM: receives a program image over `uart_rx` and writes it into the ROM word by word.
- Replaces direct bench pokes of ROM contents; the CPU fetches the same ROM as the reader.
- Holds the CPU in reset while loading and releases it on successful completion.
- Sits in `mother_board` between the `uart_rx` pin, the ROM write port and the CPU reset.

---
 rtl/uart_rom_loader_pkg.sv | 35 +++
 rtl/uart_rom_loader_if.sv | 22 ++
 rtl/uart_rom_loader_rx_core.sv | 108 ++++++++++
 rtl/uart_rom_loader.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/uart_rom_loader_pkg.sv
// Shared types and constants for the UART ROM loader.
// LOADER_CHECKSUM_EN (in the loader top) enables the trailing checksum byte and the CSUM state.
package uart_rom_loader_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int WORD_BYTES     = 4;
    localparam int LEN_BYTES      = 2;
    localparam int BIT_IDX_W      = $clog2(UART_DATA_BITS);
    localparam int BYTE_IDX_W     = $clog2(WORD_BYTES);

    typedef logic [8*LEN_BYTES-1:0] len_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_WORD,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // A frame may fill the ROM exactly but never exceed it, so the address never wraps.
    function automatic logic len_fits(input len_t n, input int unsigned addr_w);
        return 32'(n) <= (32'd1 << addr_w);
    endfunction

endpackage

// File: rtl/uart_rom_loader_if.sv
// ROM write port bundle: the loader drives it (master), the instruction ROM consumes it (slave).
interface uart_rom_loader_if #(
    parameter int ADDR_W = 8
);

    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_wdata;

    modport master (
        output rom_we,
        output rom_addr,
        output rom_wdata
    );

    modport slave (
        input  rom_we,
        input  rom_addr,
        input  rom_wdata
    );

endinterface

// File: rtl/uart_rom_loader_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit start validation, WAIT-cycle bit timing.
// Emits one-cycle o_rx_valid with the byte, or one-cycle o_rx_frame_err on a low stop bit.
module uart_rom_loader_rx_core
    import uart_rom_loader_pkg::*;
#(
    parameter int WAIT = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_rx,
    output logic                      o_rx_valid,
    output logic [UART_DATA_BITS-1:0] o_rx_data,
    output logic                      o_rx_frame_err
);

    localparam int CNT_W = $clog2(WAIT);

    rx_state_t                 r_state;
    logic                      r_rx_meta;
    logic                      r_rx_sync;
    logic                      r_rx_prev;
    logic [CNT_W-1:0]          r_cnt;
    logic [BIT_IDX_W-1:0]      r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_valid;
    logic                      r_frame_err;

    logic w_tick_half;
    logic w_tick_full;
    logic w_fall;

    assign w_tick_half = (r_cnt == CNT_W'(WAIT / 2 - 1));
    assign w_tick_full = (r_cnt == CNT_W'(WAIT - 1));
    assign w_fall      = r_rx_prev & ~r_rx_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_meta   <= 1'b1;
            r_rx_sync   <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_state     <= RX_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_meta   <= i_rx;
            r_rx_sync   <= r_rx_meta;
            r_rx_prev   <= r_rx_sync;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (w_fall) begin
                        r_cnt   <= '0;
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    // A line that is high again at mid-start was only a glitch.
                    if (w_tick_half) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (w_tick_full) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_sync, r_shift[UART_DATA_BITS-1:1]};
                        if (r_bit_idx == BIT_IDX_W'(UART_DATA_BITS - 1)) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (w_tick_full) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (r_rx_sync) begin
                            r_valid <= 1'b1;
                            r_data  <= r_shift;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign o_rx_valid     = r_valid;
    assign o_rx_data      = r_data;
    assign o_rx_frame_err = r_frame_err;

endmodule

// File: rtl/uart_rom_loader.sv
// Loads a program image from UART into the instruction ROM, holding the CPU in reset until done.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (CSUM state).
module uart_rom_loader
    import uart_rom_loader_pkg::*;
#(
    parameter int WAIT   = 8,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_uart_rx,
    uart_rom_loader_if.master o_rom,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    logic                      w_rx_valid;
    logic [UART_DATA_BITS-1:0] w_rx_data;
    logic                      w_rx_frame_err;
    len_t                      w_len;

    loader_state_t             r_state;
    logic                      r_rom_we;
    logic [ADDR_W-1:0]         r_rom_addr;
    logic [31:0]               r_rom_wdata;
    logic [BYTE_IDX_W-1:0]     r_byte_idx;
    logic [UART_DATA_BITS-1:0] r_len_lo;
    len_t                      r_words_left;
    logic                      r_cpu_hold;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_error;
`ifdef LOADER_CHECKSUM_EN
    logic [UART_DATA_BITS-1:0] r_csum;
`endif

    uart_rom_loader_rx_core #(
        .WAIT (WAIT)
    ) u_rx (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_rx           (i_uart_rx),
        .o_rx_valid     (w_rx_valid),
        .o_rx_data      (w_rx_data),
        .o_rx_frame_err (w_rx_frame_err)
    );

    assign w_len = {w_rx_data, r_len_lo};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_rom_we     <= 1'b0;
            r_rom_addr   <= '0;
            r_rom_wdata  <= '0;
            r_byte_idx   <= '0;
            r_len_lo     <= '0;
            r_words_left <= '0;
            r_cpu_hold   <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_rom_we <= 1'b0;
            if (w_rx_frame_err && (r_state != ST_ERROR)) begin
                r_state    <= ST_ERROR;
                r_error    <= 1'b1;
                r_busy     <= 1'b0;
                r_cpu_hold <= 1'b1;
                r_done     <= 1'b0;
            end else begin
                case (r_state)
                    // The first byte of any new frame is LEN_LO; reloading restarts at address 0.
                    ST_IDLE, ST_LEN0, ST_DONE: begin
                        if (w_rx_valid) begin
                            r_len_lo   <= w_rx_data;
                            r_rom_addr <= '0;
                            r_byte_idx <= '0;
                            r_busy     <= 1'b1;
                            r_done     <= 1'b0;
                            r_cpu_hold <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                            r_csum     <= w_rx_data;
`endif
                            r_state    <= ST_LEN1;
                        end
                    end
                    ST_LEN1: begin
                        if (w_rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
                            r_csum <= r_csum ^ w_rx_data;
`endif
                            if (!len_fits(w_len, ADDR_W)) begin
                                r_state    <= ST_ERROR;
                                r_error    <= 1'b1;
                                r_busy     <= 1'b0;
                                r_cpu_hold <= 1'b1;
                                r_done     <= 1'b0;
                            end else if (w_len == '0) begin
`ifdef LOADER_CHECKSUM_EN
                                r_state    <= ST_CSUM;
`else
                                r_state    <= ST_DONE;
                                r_done     <= 1'b1;
                                r_busy     <= 1'b0;
                                r_cpu_hold <= 1'b0;
`endif
                            end else begin
                                r_words_left <= w_len;
                                r_state      <= ST_WORD;
                            end
                        end
                    end
                    ST_WORD: begin
                        // Completion is decided in the write cycle so done always trails the last rom_we.
                        if (r_rom_we) begin
                            if (r_words_left == '0) begin
`ifdef LOADER_CHECKSUM_EN
                                r_state    <= ST_CSUM;
`else
                                r_state    <= ST_DONE;
                                r_done     <= 1'b1;
                                r_busy     <= 1'b0;
                                r_cpu_hold <= 1'b0;
`endif
                            end else begin
                                r_rom_addr <= r_rom_addr + ADDR_W'(1);
                            end
                        end else if (w_rx_valid) begin
                            r_rom_wdata[{r_byte_idx, 3'b000} +: 8] <= w_rx_data;
                            r_byte_idx <= r_byte_idx + BYTE_IDX_W'(1);
`ifdef LOADER_CHECKSUM_EN
                            r_csum     <= r_csum ^ w_rx_data;
`endif
                            if (r_byte_idx == BYTE_IDX_W'(WORD_BYTES - 1)) begin
                                r_rom_we     <= 1'b1;
                                r_words_left <= r_words_left - len_t'(1);
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    ST_CSUM: begin
                        if (w_rx_valid) begin
                            if (w_rx_data == r_csum) begin
                                r_state    <= ST_DONE;
                                r_done     <= 1'b1;
                                r_busy     <= 1'b0;
                                r_cpu_hold <= 1'b0;
                            end else begin
                                r_state    <= ST_ERROR;
                                r_error    <= 1'b1;
                                r_busy     <= 1'b0;
                                r_cpu_hold <= 1'b1;
                                r_done     <= 1'b0;
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign o_rom.rom_we    = r_rom_we;
    assign o_rom.rom_addr  = r_rom_addr;
    assign o_rom.rom_wdata = r_rom_wdata;
    assign o_cpu_hold      = r_cpu_hold;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_error         = r_error;

endmodule
